// File: rtl/placement_readback_if.sv
// Bundles the placement RAM read ports and the per-node record stream.
// Latency: n/a (wires only).
// Backpressure: record stream is valid/ready; RAM ports are fixed one-cycle reads.
interface placement_readback_if #(
  parameter int DW = 32
);
  logic          rePX;
  logic [DW-1:0] addrPX;
  logic [DW-1:0] doutPX;
  logic          rePY;
  logic [DW-1:0] addrPY;
  logic [DW-1:0] doutPY;
  logic          reGrid;
  logic [DW-1:0] addrGrid;
  logic [DW-1:0] doutGrid;
  logic          rec_valid;
  logic          rec_ready;
  logic [DW-1:0] rec_node;
  logic [DW-1:0] rec_x;
  logic [DW-1:0] rec_y;
  logic [2:0]    rec_flags;

  // Reader side: drives strobes/addresses and records.
  modport master (
    output rePX, addrPX, rePY, addrPY, reGrid, addrGrid,
    input  doutPX, doutPY, doutGrid,
    output rec_valid, rec_node, rec_x, rec_y, rec_flags,
    input  rec_ready
  );

  // Memory and record-consumer side.
  modport slave (
    input  rePX, addrPX, rePY, addrPY, reGrid, addrGrid,
    output doutPX, doutPY, doutGrid,
    input  rec_valid, rec_node, rec_x, rec_y, rec_flags,
    output rec_ready
  );
endinterface

// File: rtl/placement_readback.sv
// Walks placer result RAMs, cross-checks grid vs positions, streams node records, counts occupied cells.
// Latency: 3 or 5 cycles per node (plus stalls) + 2*N*N scan + start/FIN overhead; all outputs registered.
// Backpressure: rec_valid holds record stable until rec_ready; no further RAM reads while stalled.
module placement_readback #(
  parameter int N       = 6,
  parameter int N_NODES = 18,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] placed_cnt,
  output logic [DW-1:0] unplaced_cnt,
  output logic [DW-1:0] mismatch_cnt,
  output logic [DW-1:0] occupied_cnt,
  output logic          ok,
  placement_readback_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, POS_RD, POS_WT, GR_RD, GR_WT, EMIT, SC_RD, SC_WT, FIN
  } state_t;

  localparam logic [DW-1:0] EMPTY     = {DW{1'b1}};
  localparam logic [DW-1:0] MAX_COORD = DW'(N - 1);
  localparam logic [DW-1:0] LAST_NODE = DW'(N_NODES - 1);
  localparam logic [DW-1:0] LAST_CELL = DW'(N * N - 1);

  localparam logic [2:0] F_UNPLACED = 3'b001;
  localparam logic [2:0] F_OOR      = 3'b010;
  localparam logic [2:0] F_MISMATCH = 3'b100;

  state_t        state_q, state_d;
  logic [DW-1:0] node_q, node_d;
  logic [DW-1:0] cell_q, cell_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]    flags_q, flags_d;
  logic [DW-1:0] placed_q, placed_d, unpl_q, unpl_d;
  logic [DW-1:0] mis_q, mis_d, occ_q, occ_d;
  logic          busy_q, busy_d, done_q, done_d, ok_q, ok_d;
  logic          rePX_q, rePX_d, rePY_q, rePY_d, reGrid_q, reGrid_d;
  logic [DW-1:0] addrP_q, addrP_d, addrGrid_q, addrGrid_d;
  logic          rec_valid_q, rec_valid_d;

  // Saturating counter increment.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (&v) ? v : v + DW'(1);
  endfunction

  logic          x_unpl, y_unpl, x_oor, y_oor;
  logic [DW-1:0] grid_addr;
  logic [DW-1:0] occ_nx;

  // Next-state and registered-output computation; strobes default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    cell_d      = cell_q;
    x_d         = x_q;
    y_d         = y_q;
    flags_d     = flags_q;
    placed_d    = placed_q;
    unpl_d      = unpl_q;
    mis_d       = mis_q;
    occ_d       = occ_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    rePX_d      = 1'b0;
    rePY_d      = 1'b0;
    reGrid_d    = 1'b0;
    addrP_d     = addrP_q;
    addrGrid_d  = addrGrid_q;
    rec_valid_d = rec_valid_q;

    x_unpl    = (bus.doutPX == EMPTY);
    y_unpl    = (bus.doutPY == EMPTY);
    x_oor     = ($signed(bus.doutPX) < 0) || ($signed(bus.doutPX) > $signed(MAX_COORD));
    y_oor     = ($signed(bus.doutPY) < 0) || ($signed(bus.doutPY) > $signed(MAX_COORD));
    grid_addr = bus.doutPX * DW'(N) + bus.doutPY;
    occ_nx    = (bus.doutGrid != EMPTY) ? sat_inc(occ_q) : occ_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = POS_RD;
          placed_d = '0;
          unpl_d   = '0;
          mis_d    = '0;
          occ_d    = '0;
          ok_d     = 1'b0;
          busy_d   = 1'b1;
          node_d   = '0;
          rePX_d   = 1'b1;
          rePY_d   = 1'b1;
          addrP_d  = '0;
        end
      end
      POS_RD: state_d = POS_WT;
      POS_WT: begin
        x_d = bus.doutPX;
        y_d = bus.doutPY;
        if (x_unpl || y_unpl) begin
          flags_d     = F_UNPLACED;
          unpl_d      = sat_inc(unpl_q);
          rec_valid_d = 1'b1;
          state_d     = EMIT;
        end else if (x_oor || y_oor) begin
          flags_d     = F_OOR;
          mis_d       = sat_inc(mis_q);
          rec_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          flags_d    = '0;
          reGrid_d   = 1'b1;
          addrGrid_d = grid_addr;
          state_d    = GR_RD;
        end
      end
      GR_RD: state_d = GR_WT;
      GR_WT: begin
        placed_d = sat_inc(placed_q);
        if (bus.doutGrid != node_q) begin
          flags_d = F_MISMATCH;
          mis_d   = sat_inc(mis_q);
        end
        rec_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (rec_valid_q && bus.rec_ready) begin
          rec_valid_d = 1'b0;
          if (node_q == LAST_NODE) begin
            cell_d     = '0;
            reGrid_d   = 1'b1;
            addrGrid_d = '0;
            state_d    = SC_RD;
          end else begin
            node_d  = node_q + DW'(1);
            rePX_d  = 1'b1;
            rePY_d  = 1'b1;
            addrP_d = node_q + DW'(1);
            state_d = POS_RD;
          end
        end
      end
      SC_RD: state_d = SC_WT;
      SC_WT: begin
        occ_d = occ_nx;
        if (cell_q == LAST_CELL) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ok_d    = (unpl_q == '0) && (mis_q == '0) && (occ_nx == placed_q);
          state_d = FIN;
        end else begin
          cell_d     = cell_q + DW'(1);
          reGrid_d   = 1'b1;
          addrGrid_d = cell_q + DW'(1);
          state_d    = SC_RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any walk immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      node_q      <= '0;
      cell_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      placed_q    <= '0;
      unpl_q      <= '0;
      mis_q       <= '0;
      occ_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      rePX_q      <= 1'b0;
      rePY_q      <= 1'b0;
      reGrid_q    <= 1'b0;
      addrP_q     <= '0;
      addrGrid_q  <= '0;
      rec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      cell_q      <= cell_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      placed_q    <= placed_d;
      unpl_q      <= unpl_d;
      mis_q       <= mis_d;
      occ_q       <= occ_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      rePX_q      <= rePX_d;
      rePY_q      <= rePY_d;
      reGrid_q    <= reGrid_d;
      addrP_q     <= addrP_d;
      addrGrid_q  <= addrGrid_d;
      rec_valid_q <= rec_valid_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ok            = ok_q;
  assign placed_cnt    = placed_q;
  assign unplaced_cnt  = unpl_q;
  assign mismatch_cnt  = mis_q;
  assign occupied_cnt  = occ_q;
  assign bus.rePX      = rePX_q;
  assign bus.rePY      = rePY_q;
  assign bus.addrPX    = addrP_q;
  assign bus.addrPY    = addrP_q;
  assign bus.reGrid    = reGrid_q;
  assign bus.addrGrid  = addrGrid_q;
  assign bus.rec_valid = rec_valid_q;
  assign bus.rec_node  = node_q;
  assign bus.rec_x     = x_q;
  assign bus.rec_y     = y_q;
  assign bus.rec_flags = flags_q;

endmodule

// File: tb/tb_placement_readback.sv
// Bench for placement_readback: RAM models, record scoreboard vs a loop-level reference, directed table + random runs.
// Latency: n/a.
// Backpressure: rec_ready driven tied-high, random, or held low for the first record.
module tb_placement_readback;
  localparam int N     = 6;
  localparam int NN    = 18;
  localparam int DW    = 32;
  localparam int CELLS = N * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, ok;
  logic [DW-1:0] placed_cnt, unplaced_cnt, mismatch_cnt, occupied_cnt;

  placement_readback_if #(.DW(DW)) bus ();

  placement_readback #(.N(N), .N_NODES(NN), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .placed_cnt(placed_cnt), .unplaced_cnt(unplaced_cnt),
    .mismatch_cnt(mismatch_cnt), .occupied_cnt(occupied_cnt),
    .ok(ok), .bus(bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Placement memories as the placer would leave them.
  int px_m[NN];
  int py_m[NN];
  int grid_m[CELLS];
  int a_px, a_py, a_gr;

  // Synchronous-read RAMs: address captured at the edge ending the strobe cycle.
  always @(posedge clk) begin
    a_px = int'(bus.addrPX);
    a_py = int'(bus.addrPY);
    a_gr = int'(bus.addrGrid);
    if (bus.rePX) bus.doutPX <= (a_px < NN) ? px_m[a_px] : -1;
    if (bus.rePY) bus.doutPY <= (a_py < NN) ? py_m[a_py] : -1;
    if (bus.reGrid) bus.doutGrid <= (a_gr < CELLS) ? grid_m[a_gr] : -1;
  end

  // Reference: expected record list and summary from plain per-node/per-cell rules.
  typedef struct { int node; int x; int y; logic [2:0] flags; } rec_t;
  rec_t expq[$];
  int   m_placed, m_unpl, m_mis, m_occ;
  bit   m_ok;

  function automatic void build_model();
    rec_t r;
    expq.delete();
    m_placed = 0; m_unpl = 0; m_mis = 0; m_occ = 0;
    for (int n = 0; n < NN; n++) begin
      r.node = n; r.x = px_m[n]; r.y = py_m[n]; r.flags = 3'b000;
      if (r.x == -1 || r.y == -1) begin
        r.flags = 3'b001; m_unpl++;
      end else if (r.x < 0 || r.x >= N || r.y < 0 || r.y >= N) begin
        r.flags = 3'b010; m_mis++;
      end else begin
        m_placed++;
        if (grid_m[r.x * N + r.y] != n) begin
          r.flags = 3'b100; m_mis++;
        end
      end
      expq.push_back(r);
    end
    for (int c = 0; c < CELLS; c++) if (grid_m[c] != -1) m_occ++;
    m_ok = (m_unpl == 0) && (m_mis == 0) && (m_occ == m_placed);
  endfunction

  // kind 0 consistent, 1 node5 unplaced, 2 grid[15]=7 with node4 at (2,3), 3 node9 at (6,0), 4 random.
  function automatic void set_scenario(int kind);
    int c;
    for (int i = 0; i < CELLS; i++) grid_m[i] = -1;
    if (kind == 4) begin
      for (int i = 0; i < NN; i++) begin
        c = int'($urandom_range(0, 9));
        if (c == 0) begin
          px_m[i] = -1; py_m[i] = -1;
        end else if (c == 1) begin
          px_m[i] = ($urandom_range(0, 1) == 1) ? N + int'($urandom_range(0, 3)) : -2 - int'($urandom_range(0, 3));
          py_m[i] = int'($urandom_range(0, N - 1));
        end else begin
          c = int'($urandom_range(0, CELLS - 1));
          px_m[i] = c / N; py_m[i] = c % N; grid_m[c] = i;
        end
      end
      for (int k = 0; k < 3; k++) grid_m[$urandom_range(0, CELLS - 1)] = int'($urandom_range(0, 20)) - 1;
    end else begin
      for (int i = 0; i < NN; i++) begin
        c = (i * 7) % CELLS;
        px_m[i] = c / N; py_m[i] = c % N; grid_m[c] = i;
      end
      if (kind == 1) begin px_m[5] = -1; py_m[5] = -1; grid_m[35] = -1; end
      if (kind == 2) begin grid_m[28] = -1; px_m[4] = 2; py_m[4] = 3; grid_m[15] = 7; end
      if (kind == 3) begin grid_m[27] = -1; px_m[9] = 6; py_m[9] = 0; end
    end
  endfunction

  // Stream monitor: scoreboard, stability under stall, strobe counting.
  int         px_reads, grid_reads, done_cnt, rec_seen, stall_cyc;
  logic [2:0] got_flags[NN];
  bit         prev_v = 1'b0;
  rec_t       held, e;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rePX) px_reads++;
      if (bus.reGrid) grid_reads++;
      if (done) done_cnt++;
      if (prev_v) begin
        if (!bus.rec_valid) chk("valid_dropped_without_handshake", 0, 1);
        else begin
          chk("stall_node_stable", bus.rec_node, held.node);
          chk("stall_x_stable", bus.rec_x, held.x);
          chk("stall_y_stable", bus.rec_y, held.y);
          chk("stall_flags_stable", {29'd0, bus.rec_flags}, {29'd0, held.flags});
        end
      end
      prev_v = 1'b0;
      if (bus.rec_valid) begin
        if (!bus.rec_ready) begin
          stall_cyc++;
          chk("no_pos_read_while_stalled", {31'd0, bus.rePX}, 0);
          held.node = int'(bus.rec_node); held.x = int'(bus.rec_x);
          held.y = int'(bus.rec_y); held.flags = bus.rec_flags;
          prev_v = 1'b1;
        end else begin
          if (expq.size() == 0) chk("unexpected_record", 1, 0);
          else begin
            e = expq.pop_front();
            chk("rec_node", bus.rec_node, e.node);
            chk("rec_x", bus.rec_x, e.x);
            chk("rec_y", bus.rec_y, e.y);
            chk("rec_flags", {29'd0, bus.rec_flags}, {29'd0, e.flags});
          end
          if (bus.rec_node < NN) got_flags[bus.rec_node] = bus.rec_flags;
          rec_seen++;
        end
      end
    end
  end

  task automatic clear_mon();
    px_reads = 0; grid_reads = 0; done_cnt = 0; rec_seen = 0; stall_cyc = 0;
    for (int i = 0; i < NN; i++) got_flags[i] = 3'bxxx;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_ok"}, {31'd0, ok}, 0);
    chk({tag, "_placed"}, placed_cnt, 0);
    chk({tag, "_unplaced"}, unplaced_cnt, 0);
    chk({tag, "_mismatch"}, mismatch_cnt, 0);
    chk({tag, "_occupied"}, occupied_cnt, 0);
    chk({tag, "_strobes"}, {29'd0, bus.rePX, bus.rePY, bus.reGrid}, 0);
    chk({tag, "_addrPX"}, bus.addrPX, 0);
    chk({tag, "_addrGrid"}, bus.addrGrid, 0);
    chk({tag, "_rec_valid"}, {31'd0, bus.rec_valid}, 0);
    chk({tag, "_rec_fields"}, bus.rec_node | bus.rec_x | bus.rec_y | {29'd0, bus.rec_flags}, 0);
  endtask

  // One full walk. mode 0: ready high, 1: random ready, 2: first record stalled + start pulse mid-scan.
  task automatic do_run(input int mode, input int e_pl, input int e_un, input int e_mi,
                        input int e_oc, input bit e_ok, input int fnode, input logic [2:0] fexp);
    bit fin;
    bit inj;
    int cyc;
    fin = 1'b0; inj = 1'b0; cyc = 0;
    clear_mon();
    bus.rec_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin
        int k;
        k = 0;
        while (!fin) begin
          @(posedge clk); #1;
          if (mode == 1) bus.rec_ready = ($urandom_range(0, 2) != 0);
          if (mode == 2) begin
            if (bus.rec_valid) k++;
            bus.rec_ready = (k > 10);
          end
        end
      end
      begin
        while (!fin) begin
          @(negedge clk);
          cyc++;
          if (done) fin = 1'b1;
          else if (cyc > 4000) begin
            chk("done_timeout", 0, 1);
            fin = 1'b1;
          end else if (mode == 2 && !inj && rec_seen == NN) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            inj = 1'b1;
          end
        end
      end
    join
    chk("placed_cnt", placed_cnt, e_pl);
    chk("unplaced_cnt", unplaced_cnt, e_un);
    chk("mismatch_cnt", mismatch_cnt, e_mi);
    chk("occupied_cnt", occupied_cnt, e_oc);
    chk("ok", {31'd0, ok}, {31'd0, e_ok});
    chk("busy_low_at_done", {31'd0, busy}, 0);
    if (fnode >= 0) chk("flag_of_node", {29'd0, got_flags[fnode]}, {29'd0, fexp});
    repeat (6) @(negedge clk);
    chk("records_seen", rec_seen, NN);
    chk("records_left", expq.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("pos_reads", px_reads, NN);
    chk("grid_reads", grid_reads, e_pl + CELLS);
    chk("busy_idle_after", {31'd0, busy}, 0);
    chk("summary_held", occupied_cnt, e_oc);
    if (mode == 2) chk("stall_ge_10", {31'd0, stall_cyc >= 10}, 1);
  endtask

  typedef struct {
    int kind; int mode;
    int e_pl; int e_un; int e_mi; int e_oc; bit e_ok;
    int fnode; logic [2:0] fexp;
  } vec_t;

  vec_t vecs[6];
  int   cyc;

  initial begin
    vecs[0] = '{0, 0, 18, 0, 0, 18, 1'b1, 0, 3'b000};
    vecs[1] = '{1, 0, 17, 1, 0, 17, 1'b0, 5, 3'b001};
    vecs[2] = '{2, 0, 18, 0, 1, 18, 1'b0, 4, 3'b100};
    vecs[3] = '{3, 0, 17, 0, 1, 17, 1'b0, 9, 3'b010};
    vecs[4] = '{0, 2, 18, 0, 0, 18, 1'b1, 0, 3'b000};
    vecs[5] = '{2, 1, 18, 0, 1, 18, 1'b0, 4, 3'b100};

    bus.rec_ready = 1'b1;
    set_scenario(0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      set_scenario(vecs[v].kind);
      build_model();
      do_run(vecs[v].mode, vecs[v].e_pl, vecs[v].e_un, vecs[v].e_mi,
             vecs[v].e_oc, vecs[v].e_ok, vecs[v].fnode, vecs[v].fexp);
    end

    for (int r = 0; r < 4; r++) begin
      set_scenario(4);
      build_model();
      do_run(1, m_placed, m_unpl, m_mis, m_occ, m_ok, -1, 3'b000);
    end

    // Reset while the scan is waiting on its first grid read.
    set_scenario(0);
    build_model();
    clear_mon();
    bus.rec_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(rec_seen == NN && bus.reGrid) && cyc < 2000);
    if (cyc >= 2000) chk("scan_wait_timeout", 0, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    chk("no_done_on_abort", done_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;
    build_model();
    do_run(0, 18, 0, 0, 18, 1'b1, 0, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
